// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//
// Instruction fetch queue. Holds the fetch PC, drives it straight onto
// rom_addr, and captures up to two instructions per cycle from the ROM into a
// circular buffer. Decode sees the two oldest entries and pops every valid
// slot when it is ready. A redirect flushes the queue and reloads the PC.
//
// Parameters
//   ADDR_WIDTH  PC / address width
//   DATA_WIDTH  instruction width
//   DEPTH       queue entries (power of two, >= 4)
//   RESET_PC    PC value after reset
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   rom_addr                    fetch address (the PC register)
//   rom_inst_0 / rom_inst_1     instructions at rom_addr / rom_addr+4
//   rom_valid[1:0]              per-slot ROM valid (2'b10 is ignored)
//   redirect_valid/redirect_pc  flush and PC reload
//   dec_ready                   decode accepts all valid output slots
//   dec_valid[1:0]              output slot valid, bit0 oldest
//   dec_pc_0/1, dec_inst_0/1    oldest / second-oldest entry
//   occupancy                   number of stored entries
// -----------------------------------------------------------------------------
module fetch_queue #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           DEPTH      = 8,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    output logic [ADDR_WIDTH-1:0]     rom_addr,
    input  logic [DATA_WIDTH-1:0]     rom_inst_0,
    input  logic [DATA_WIDTH-1:0]     rom_inst_1,
    input  logic [1:0]                rom_valid,
    input  logic                      redirect_valid,
    input  logic [ADDR_WIDTH-1:0]     redirect_pc,
    input  logic                      dec_ready,
    output logic [1:0]                dec_valid,
    output logic [ADDR_WIDTH-1:0]     dec_pc_0,
    output logic [ADDR_WIDTH-1:0]     dec_pc_1,
    output logic [DATA_WIDTH-1:0]     dec_inst_0,
    output logic [DATA_WIDTH-1:0]     dec_inst_1,
    output logic [$clog2(DEPTH):0]    occupancy
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;

    logic [ADDR_WIDTH-1:0] pc;
    logic [PTR_W-1:0]      head;
    logic [PTR_W-1:0]      tail;
    logic [OCC_W-1:0]      occ;

    // Data array carries no reset; entries are only visible once written.
    logic [ADDR_WIDTH-1:0] mem_pc   [DEPTH];
    logic [DATA_WIDTH-1:0] mem_inst [DEPTH];

    logic [OCC_W-1:0]      free_slots;
    logic                  fetch_en;
    logic [1:0]            n_enq;
    logic [1:0]            n_deq;
    logic [PTR_W-1:0]      head_p1;
    logic [PTR_W-1:0]      tail_p1;

    assign rom_addr  = pc;
    assign occupancy = occ;

    // Two free slots are always required, so a double enqueue never
    // overwrites a live entry even when decode pops nothing.
    assign free_slots = OCC_W'(DEPTH) - occ;
    assign fetch_en   = !redirect_valid && (free_slots >= OCC_W'(2));

    // Slot 1 alone (rom_valid = 2'b10) cannot be enqueued out of order.
    always_comb begin
        n_enq = 2'd0;
        if (fetch_en && rom_valid[0]) begin
            n_enq = rom_valid[1] ? 2'd2 : 2'd1;
        end
    end

    assign dec_valid[0] = !redirect_valid && (occ != '0);
    assign dec_valid[1] = !redirect_valid && (occ > OCC_W'(1));

    always_comb begin
        n_deq = 2'd0;
        if (dec_ready) begin
            n_deq = {1'b0, dec_valid[0]} + {1'b0, dec_valid[1]};
        end
    end

    assign head_p1 = head + PTR_W'(1);
    assign tail_p1 = tail + PTR_W'(1);

    assign dec_pc_0   = mem_pc[head];
    assign dec_inst_0 = mem_inst[head];
    assign dec_pc_1   = mem_pc[head_p1];
    assign dec_inst_1 = mem_inst[head_p1];

    // Control state: PC, pointers, occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc   <= RESET_PC;
            head <= '0;
            tail <= '0;
            occ  <= '0;
        end else if (redirect_valid) begin
            pc   <= redirect_pc;
            head <= '0;
            tail <= '0;
            occ  <= '0;
        end else begin
            pc   <= pc + ADDR_WIDTH'({n_enq, 2'b00});
            head <= head + PTR_W'(n_deq);
            tail <= tail + PTR_W'(n_enq);
            occ  <= occ + OCC_W'(n_enq) - OCC_W'(n_deq);
        end
    end

    // Data array writes. n_enq is already zero on a redirect.
    always_ff @(posedge clk) begin
        if (n_enq != 2'd0) begin
            mem_pc[tail]   <= pc;
            mem_inst[tail] <= rom_inst_0;
        end
        if (n_enq == 2'd2) begin
            mem_pc[tail_p1]   <= pc + ADDR_WIDTH'(4);
            mem_inst[tail_p1] <= rom_inst_1;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_fetch_queue
//
// Self-checking bench for fetch_queue. A queue-based reference model tracks
// the expected PC and stored {pc, inst} entries; directed scenarios are
// followed by a randomized run.
// -----------------------------------------------------------------------------
module tb_fetch_queue;

    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 8;
    localparam logic [31:0] RPC   = 32'h0;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_inst_0;
    logic [DW-1:0] rom_inst_1;
    logic [1:0]    rom_valid;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic          dec_ready;
    logic [1:0]    dec_valid;
    logic [AW-1:0] dec_pc_0;
    logic [AW-1:0] dec_pc_1;
    logic [DW-1:0] dec_inst_0;
    logic [DW-1:0] dec_inst_1;
    logic [3:0]    occupancy;

    fetch_queue #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .DEPTH(DEPTH),
        .RESET_PC(RPC)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .rom_addr(rom_addr),
        .rom_inst_0(rom_inst_0),
        .rom_inst_1(rom_inst_1),
        .rom_valid(rom_valid),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .dec_ready(dec_ready),
        .dec_valid(dec_valid),
        .dec_pc_0(dec_pc_0),
        .dec_pc_1(dec_pc_1),
        .dec_inst_0(dec_inst_0),
        .dec_inst_1(dec_inst_1),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] mpc;
    int          n_checks = 0;
    int          n_bad    = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        mpc = RPC;
    endtask

    // Called at a falling edge: drive inputs, compare outputs against the
    // model, advance the model, and return at the next falling edge.
    task automatic cycle(input logic [1:0] rv, input logic rdy,
                         input logic redir, input logic [31:0] rpc);
        int   sz;
        int   n_deq;
        ent_t e;
        rom_valid      = rv;
        dec_ready      = rdy;
        redirect_valid = redir;
        redirect_pc    = rpc;
        rom_inst_0     = $urandom;
        rom_inst_1     = $urandom;
        #1;
        sz = mq.size();
        chk("rom_addr", rom_addr, mpc);
        chk("occupancy", occupancy, sz);
        chk("dec_valid", dec_valid, {(!redir && sz > 1), (!redir && sz > 0)});
        if (!redir && sz > 0) begin
            chk("dec_pc_0", dec_pc_0, mq[0].pc);
            chk("dec_inst_0", dec_inst_0, mq[0].inst);
        end
        if (!redir && sz > 1) begin
            chk("dec_pc_1", dec_pc_1, mq[1].pc);
            chk("dec_inst_1", dec_inst_1, mq[1].inst);
        end
        if (redir) begin
            mq.delete();
            mpc = rpc;
        end else begin
            n_deq = rdy ? ((sz > 2) ? 2 : sz) : 0;
            repeat (n_deq) e = mq.pop_front();
            if ((int'(DEPTH) - sz >= 2) && rv[0]) begin
                mq.push_back('{mpc, rom_inst_0});
                mpc += 32'd4;
                if (rv[1]) begin
                    mq.push_back('{mpc, rom_inst_1});
                    mpc += 32'd4;
                end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        int thr;
        logic [1:0]  rv;
        logic        rdy;
        logic        redir;
        logic [31:0] rpc;

        rom_valid      = 2'b00;
        rom_inst_0     = '0;
        rom_inst_1     = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        dec_ready      = 1'b0;
        model_reset();

        // Reset state
        #12;
        chk("rst_rom_addr", rom_addr, RPC);
        chk("rst_occupancy", occupancy, 0);
        chk("rst_dec_valid", dec_valid, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;

        // Straight-line fill, decode stalled
        for (int i = 0; i < 4; i++) begin
            chk("fill_addr", rom_addr, 8 * i);
            cycle(2'b11, 1'b0, 1'b0, '0);
            chk("fill_occ", occupancy, 2 * (i + 1));
        end
        for (int i = 0; i < 2; i++) begin
            cycle(2'b11, 1'b0, 1'b0, '0);
            chk("full_addr", rom_addr, 32'h20);
            chk("full_occ", occupancy, 8);
        end

        // Drain while full; pointers wrap during this phase
        cycle(2'b11, 1'b1, 1'b0, '0);
        chk("drain_occ", occupancy, 6);
        chk("drain_addr", rom_addr, 32'h20);
        for (int i = 0; i < 11; i++) cycle(2'b11, 1'b1, 1'b0, '0);

        // End of program at 0x10
        cycle(2'b00, 1'b1, 1'b1, 32'h10);
        chk("eop_redir_addr", rom_addr, 32'h10);
        chk("eop_redir_occ", occupancy, 0);
        cycle(2'b10, 1'b0, 1'b0, '0);
        chk("slot1_only_addr", rom_addr, 32'h10);
        chk("slot1_only_occ", occupancy, 0);
        cycle(2'b01, 1'b0, 1'b0, '0);
        chk("eop_addr", rom_addr, 32'h14);
        chk("eop_occ", occupancy, 1);
        chk("eop_pc", dec_pc_0, 32'h10);
        cycle(2'b00, 1'b0, 1'b0, '0);
        chk("eop_hold_addr", rom_addr, 32'h14);
        chk("eop_hold_occ", occupancy, 1);

        // Odd occupancy: pop one, push two
        cycle(2'b11, 1'b1, 1'b0, '0);
        chk("odd_occ", occupancy, 2);
        chk("odd_addr", rom_addr, 32'h1c);

        // Redirect with a full queue and decode ready
        for (int i = 0; i < 3; i++) cycle(2'b11, 1'b0, 1'b0, '0);
        chk("pre_redir_occ", occupancy, 8);
        cycle(2'b11, 1'b1, 1'b1, 32'h40);
        chk("redir_occ", occupancy, 0);
        chk("redir_addr", rom_addr, 32'h40);
        cycle(2'b11, 1'b0, 1'b0, '0);
        chk("redir_pc0", dec_pc_0, 32'h40);
        chk("redir_pc1", dec_pc_1, 32'h44);

        // Mid-run reset with occupancy 5 and PC 0x28
        cycle(2'b00, 1'b0, 1'b1, 32'h14);
        cycle(2'b11, 1'b0, 1'b0, '0);
        cycle(2'b11, 1'b0, 1'b0, '0);
        cycle(2'b01, 1'b0, 1'b0, '0);
        chk("prerst_occ", occupancy, 5);
        chk("prerst_addr", rom_addr, 32'h28);
        rom_valid = 2'b11;
        dec_ready = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_occ", occupancy, 0);
        chk("async_rst_valid", dec_valid, 2'b00);
        chk("async_rst_addr", rom_addr, RPC);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        #1;
        chk("post_rst_addr", rom_addr, RPC);
        chk("post_rst_valid", dec_valid, 2'b00);

        // Randomized run, alternating between mostly-stalled and
        // mostly-ready decode so both full and empty regions are visited
        for (int i = 0; i < 3000; i++) begin
            thr   = ((i / 250) % 2 == 1) ? 85 : 30;
            rv    = 2'($urandom);
            rdy   = ($urandom_range(0, 99) < thr);
            redir = ($urandom_range(0, 24) == 0);
            rpc   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
            cycle(rv, rdy, redir, rpc);
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
